xgmii_switch_32b: RTL

XGMII_SWITCH_32B -- requirements
Module: xgmii_switch_32b

---
 rtl/gtype.sv | 45 ++++
 rtl/xgmii_switch_port.sv | 121 ++++++++++++
 rtl/xgmii_switch_32b.sv | 38 +++
 3 files changed

// File: rtl/gtype.sv
// Shared XGMII 32-bit word type, control constants and word classifiers.
// Used by the switch top and by the per-output switching port.
package gtype;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  ctrl;
    } xgmii32_t;

    localparam logic [7:0] XGMII_START = 8'hFB;
    localparam logic [7:0] XGMII_TERM  = 8'hFD;

    localparam xgmii32_t XGMII_IDLE = '{
        data: 32'h07070707,
        ctrl: 4'hF
    };

    localparam xgmii32_t XGMII_ABORT = '{
        data: 32'h070707FD,
        ctrl: 4'hF
    };

    typedef enum logic [1:0] {
        ST_DIS,
        ST_WAIT,
        ST_PASS,
        ST_GAP
    } port_state_t;

    function automatic logic is_start(xgmii32_t w);
        return w.ctrl[0] && (w.data[7:0] == XGMII_START);
    endfunction

    function automatic logic is_term(xgmii32_t w);
        logic t;
        t = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (w.ctrl[k] && (w.data[8*k +: 8] == XGMII_TERM)) begin
                t = 1'b1;
            end
        end
        return t;
    endfunction

endpackage

// File: rtl/xgmii_switch_port.sv
// One switched output: source mux, frame-aligned join FSM and counters.
// Ports: clk, rst (async active-low), rx (all sources), route_sel/route_en
// (request), tx (output word), route_act, frame_cnt, abort_cnt.
module xgmii_switch_port
    import gtype::*;
#(
    parameter int NUM_CH = 2,
    parameter int SEL_W  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  xgmii32_t         rx [NUM_CH],
    input  logic [SEL_W-1:0] route_sel,
    input  logic             route_en,
    output xgmii32_t         tx,
    output logic [SEL_W-1:0] route_act,
    output logic [31:0]      frame_cnt,
    output logic [15:0]      abort_cnt
);

    port_state_t      state_q;
    port_state_t      state_d;
    logic [SEL_W-1:0] act_d;
    xgmii32_t         tx_d;
    logic             frame_inc;
    logic             abort_inc;

    xgmii32_t src;
    logic     src_start;
    logic     src_term;
    logic     en_ok;
    logic     sel_chg;

    assign src       = rx[route_act];
    assign src_start = is_start(src);
    assign src_term  = is_term(src);

    // An out-of-range source request behaves like a disable.
    assign en_ok   = route_en && (int'(route_sel) < NUM_CH);
    assign sel_chg = (route_sel != route_act);

    always_comb begin
        state_d   = state_q;
        act_d     = route_act;
        tx_d      = XGMII_IDLE;
        frame_inc = 1'b0;
        abort_inc = 1'b0;
        unique case (state_q)
            ST_DIS: begin
                if (en_ok) begin
                    act_d   = route_sel;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!en_ok) begin
                    state_d = ST_DIS;
                end else if (sel_chg) begin
                    act_d = route_sel;
                end else if (src_start) begin
                    tx_d    = src;
                    state_d = ST_PASS;
                end
            end
            ST_PASS: begin
                // Source changes are ignored here; they stay
                // pending on route_sel until the frame ends.
                if (!en_ok) begin
                    tx_d      = XGMII_ABORT;
                    abort_inc = 1'b1;
                    state_d   = ST_DIS;
                end else if (src_term) begin
                    tx_d      = src;
                    frame_inc = 1'b1;
                    state_d   = src_start ? ST_PASS : ST_GAP;
                end else if (src_start) begin
                    tx_d      = XGMII_ABORT;
                    abort_inc = 1'b1;
                    state_d   = ST_WAIT;
                end else begin
                    tx_d = src;
                end
            end
            ST_GAP: begin
                if (!en_ok) begin
                    state_d = ST_DIS;
                end else if (sel_chg) begin
                    act_d   = route_sel;
                    state_d = ST_WAIT;
                end else begin
                    tx_d = src;
                    if (src_start) begin
                        state_d = ST_PASS;
                    end
                end
            end
            default: begin
                state_d = ST_DIS;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_DIS;
            route_act <= '0;
            tx        <= XGMII_IDLE;
            frame_cnt <= '0;
            abort_cnt <= '0;
        end else begin
            state_q   <= state_d;
            route_act <= act_d;
            tx        <= tx_d;
            frame_cnt <= frame_cnt + {31'b0, frame_inc};
            if (abort_inc && (abort_cnt != 16'hFFFF)) begin
                abort_cnt <= abort_cnt + 16'd1;
            end
        end
    end

endmodule

// File: rtl/xgmii_switch_32b.sv
// NUM_CH x NUM_CH XGMII 32-bit frame-aligned switch, one port per output.
// Ports: clk, rst (async active-low), rx, route_sel, route_en -> tx,
// route_act, frame_cnt, abort_cnt (all per output).
module xgmii_switch_32b
    import gtype::*;
#(
    parameter  int NUM_CH = 2,
    localparam int SEL_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  xgmii32_t         rx        [NUM_CH],
    input  logic [SEL_W-1:0] route_sel [NUM_CH],
    input  logic [NUM_CH-1:0] route_en,
    output xgmii32_t         tx        [NUM_CH],
    output logic [SEL_W-1:0] route_act [NUM_CH],
    output logic [31:0]      frame_cnt [NUM_CH],
    output logic [15:0]      abort_cnt [NUM_CH]
);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_port
        xgmii_switch_port #(
            .NUM_CH (NUM_CH),
            .SEL_W  (SEL_W)
        ) u_port (
            .clk       (clk),
            .rst       (rst),
            .rx        (rx),
            .route_sel (route_sel[i]),
            .route_en  (route_en[i]),
            .tx        (tx[i]),
            .route_act (route_act[i]),
            .frame_cnt (frame_cnt[i]),
            .abort_cnt (abort_cnt[i])
        );
    end

endmodule
